grf_wb_arbiter: RTL and testbench

GRF_WB_ARBITER -- requirements
Module: grf_wb_arbiter

---
 rtl/grf_wb_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_grf_wb_arbiter.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// grf_wb_arbiter
//
// Purpose:
//   Shares the single register-file write port between the pipeline W stage
//   and a multi-cycle (mul/div) result source. The W stage can never be
//   stalled, so it always wins the port. Multi-cycle results are parked in a
//   2-entry FIFO and drained whenever the W stage leaves the port idle.
//   A buffered result is marked dead when a W-stage write to the same register
//   happens first. The dead entry is still drained, but it drives no write.
//   A live buffered entry is visible to the hazard unit through
//   q1_pend/q2_pend.
//
// Optional feature (macro GRF_ARB_BYPASS_EN):
//   When defined, the arbiter writes a multi-cycle result straight to the
//   port in the same cycle. This happens when the FIFO is empty, the W stage
//   is idle, and md_a3 != 0. When undefined, every multi-cycle result passes
//   through the FIFO and takes at least one cycle.
//
// Ports:
//   clk                 single clock, all state on posedge
//   reset               synchronous active-high reset
//   wb_valid/wb_a3/wb_wd  W-stage write request (wb_a3 == 0 means no write)
//   md_valid/md_a3/md_wd  multi-cycle result request
//   md_ready            result can be accepted (FIFO not full)
//   RegWrite/a3/WD      register-file write port
//   q1/q2               hazard-query register addresses
//   q1_pend/q2_pend     a live buffered entry targets q1/q2
// ---------------------------------------------------------------------------
module grf_wb_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_a3,
  input  logic [31:0] wb_wd,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_a3,
  input  logic [31:0] md_wd,
  output logic        RegWrite,
  output logic [4:0]  a3,
  output logic [31:0] WD,
  input  logic [4:0]  q1,
  input  logic [4:0]  q2,
  output logic        q1_pend,
  output logic        q2_pend
);

  localparam int DEPTH = 2;

  // FIFO storage; slot 0 is always the head (shift-style queue)
  logic [4:0]  ent_a3_r   [DEPTH];
  logic [31:0] ent_wd_r   [DEPTH];
  logic        ent_live_r [DEPTH];
  logic [1:0]  count_r;

  // next-state values
  logic [4:0]  nxt_a3_s   [DEPTH];
  logic [31:0] nxt_wd_s   [DEPTH];
  logic        nxt_live_s [DEPTH];
  logic [1:0]  cnt_mid_s;
  logic [1:0]  cnt_nxt_s;

  // per-cycle decisions
  logic        wb_eff_s;
  logic        head_vld_s;
  logic        md_fire_s;
  logic        md_keep_s;
  logic        byp_s;
  logic        pop_s;
  logic        push_s;
  logic        slot_used_s [DEPTH];
  logic        live_k_s    [DEPTH];

  // Returns 1 when a live occupied slot targets register q; register 0 never pends
  function automatic logic pend_lookup(
    input logic [4:0] q,
    input logic       used0,
    input logic       live0,
    input logic [4:0] a30,
    input logic       used1,
    input logic       live1,
    input logic [4:0] a31
  );
    logic hit;
    hit = 1'b0;
    if (q != 5'd0) begin
      hit = (used0 && live0 && (a30 == q)) || (used1 && live1 && (a31 == q));
    end else begin
      hit = 1'b0;
    end
    return hit;
  endfunction

  // Handshake and grant decisions for this cycle
  always_comb begin
    // Reset drops everything in flight, including the W-stage request.
    wb_eff_s   = wb_valid && (wb_a3 != 5'd0) && !reset;
    head_vld_s = (count_r != 2'd0) && !reset;
    // md_ready depends on the stored count only and does not see a same-cycle pop.
    md_ready   = (count_r < 2'd2);
    md_fire_s  = md_valid && md_ready && !reset;
    // A result aimed at register 0 completes its handshake but is thrown away.
    md_keep_s  = md_fire_s && (md_a3 != 5'd0);
`ifdef GRF_ARB_BYPASS_EN
    byp_s      = md_keep_s && !wb_eff_s && (count_r == 2'd0);
`else
    byp_s      = 1'b0;
`endif
    pop_s      = !wb_eff_s && head_vld_s;
    push_s     = md_keep_s && !byp_s;
    slot_used_s[0] = (count_r != 2'd0);
    slot_used_s[1] = (count_r == 2'd2);
  end

  // Write-port mux: W stage first, then FIFO head, then (optionally) bypass
  always_comb begin
    RegWrite = 1'b0;
    a3       = 5'd0;
    WD       = 32'd0;
    if (wb_eff_s) begin
      RegWrite = 1'b1;
      a3       = wb_a3;
      WD       = wb_wd;
    end else if (pop_s) begin
      // A dead head still uses its slot in the grant but writes nothing.
      RegWrite = ent_live_r[0];
      a3       = ent_a3_r[0];
      WD       = ent_wd_r[0];
    end else if (byp_s) begin
      RegWrite = 1'b1;
      a3       = md_a3;
      WD       = md_wd;
    end else begin
      RegWrite = 1'b0;
      a3       = 5'd0;
      WD       = 32'd0;
    end
  end

  // Hazard queries over live buffered entries
  always_comb begin
    q1_pend = pend_lookup(q1, slot_used_s[0], ent_live_r[0], ent_a3_r[0],
                          slot_used_s[1], ent_live_r[1], ent_a3_r[1]);
    q2_pend = pend_lookup(q2, slot_used_s[0], ent_live_r[0], ent_a3_r[0],
                          slot_used_s[1], ent_live_r[1], ent_a3_r[1]);
  end

  // FIFO next state: kill matching entries, then pop, then push
  always_comb begin
    // A W-stage write to the same register makes the buffered value stale.
    for (int i = 0; i < DEPTH; i++) begin
      live_k_s[i]   = ent_live_r[i] && !(wb_eff_s && (ent_a3_r[i] == wb_a3));
      nxt_a3_s[i]   = ent_a3_r[i];
      nxt_wd_s[i]   = ent_wd_r[i];
      nxt_live_s[i] = live_k_s[i];
    end

    if (pop_s) begin
      nxt_a3_s[0]   = ent_a3_r[1];
      nxt_wd_s[0]   = ent_wd_r[1];
      nxt_live_s[0] = live_k_s[1];
      nxt_a3_s[1]   = 5'd0;
      nxt_wd_s[1]   = 32'd0;
      nxt_live_s[1] = 1'b0;
      cnt_mid_s     = count_r - 2'd1;
    end else begin
      cnt_mid_s     = count_r;
    end

    // A push only happens when count < 2, so cnt_mid_s is 0 or 1 here. The
    // newly pushed entry is younger than any W-stage write in this cycle, so
    // it is stored as live.
    if (push_s) begin
      if (cnt_mid_s == 2'd0) begin
        nxt_a3_s[0]   = md_a3;
        nxt_wd_s[0]   = md_wd;
        nxt_live_s[0] = 1'b1;
      end else begin
        nxt_a3_s[1]   = md_a3;
        nxt_wd_s[1]   = md_wd;
        nxt_live_s[1] = 1'b1;
      end
      cnt_nxt_s = cnt_mid_s + 2'd1;
    end else begin
      cnt_nxt_s = cnt_mid_s;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_a3_r[i]   <= 5'd0;
        ent_wd_r[i]   <= 32'd0;
        ent_live_r[i] <= 1'b0;
      end
    end else begin
      count_r <= cnt_nxt_s;
      for (int i = 0; i < DEPTH; i++) begin
        ent_a3_r[i]   <= nxt_a3_s[i];
        ent_wd_r[i]   <= nxt_wd_s[i];
        ent_live_r[i] <= nxt_live_s[i];
      end
    end
  end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_grf_wb_arbiter
//
// Self-checking bench for grf_wb_arbiter. The reference model is a queue of
// pending multi-cycle results, and the expected port values come from the
// arbitration rules. Inputs change 1 time unit after posedge. Outputs are
// compared 2 time units later, well before the next edge.
// ---------------------------------------------------------------------------
module tb_grf_wb_arbiter;

`ifdef GRF_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_a3;
  logic [31:0] wb_wd;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_a3;
  logic [31:0] md_wd;
  logic        RegWrite;
  logic [4:0]  a3;
  logic [31:0] WD;
  logic [4:0]  q1;
  logic [4:0]  q2;
  logic        q1_pend;
  logic        q2_pend;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0]  a3;
    logic [31:0] wd;
    bit          live;
  } ent_t;

  ent_t mq[$];

  logic        exp_ready;
  logic        exp_rw;
  logic [4:0]  exp_a3;
  logic [31:0] exp_wd;
  logic        exp_p1;
  logic        exp_p2;
  bit          byp_take;

  always #5 clk = ~clk;

  grf_wb_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .wb_valid (wb_valid),
    .wb_a3    (wb_a3),
    .wb_wd    (wb_wd),
    .md_valid (md_valid),
    .md_ready (md_ready),
    .md_a3    (md_a3),
    .md_wd    (md_wd),
    .RegWrite (RegWrite),
    .a3       (a3),
    .WD       (WD),
    .q1       (q1),
    .q2       (q2),
    .q1_pend  (q1_pend),
    .q2_pend  (q2_pend)
  );

  // Expected outputs for the current inputs and the queued results
  function automatic void model_eval();
    bit wbe;
    wbe       = wb_valid && (wb_a3 != 5'd0);
    exp_ready = (mq.size() < 2);
    exp_rw    = 1'b0;
    exp_a3    = 5'd0;
    exp_wd    = 32'd0;
    byp_take  = 1'b0;
    if (wbe) begin
      exp_rw = 1'b1; exp_a3 = wb_a3; exp_wd = wb_wd;
    end else if (mq.size() > 0) begin
      exp_rw = mq[0].live; exp_a3 = mq[0].a3; exp_wd = mq[0].wd;
    end else if (BYP && md_valid && (md_a3 != 5'd0)) begin
      exp_rw = 1'b1; exp_a3 = md_a3; exp_wd = md_wd; byp_take = 1'b1;
    end
    exp_p1 = 1'b0;
    exp_p2 = 1'b0;
    foreach (mq[i]) begin
      if (mq[i].live && (q1 != 5'd0) && (mq[i].a3 == q1)) exp_p1 = 1'b1;
      if (mq[i].live && (q2 != 5'd0) && (mq[i].a3 == q2)) exp_p2 = 1'b1;
    end
  endfunction

  // Advance the model across one clock edge (call model_eval first)
  function automatic void model_commit();
    bit   wbe;
    ent_t e;
    if (reset) begin
      mq.delete();
      return;
    end
    wbe = wb_valid && (wb_a3 != 5'd0);
    if (wbe) begin
      foreach (mq[i]) if (mq[i].a3 == wb_a3) mq[i].live = 1'b0;
    end
    if (!wbe && (mq.size() > 0)) void'(mq.pop_front());
    if (md_valid && exp_ready && (md_a3 != 5'd0) && !byp_take) begin
      e.a3 = md_a3; e.wd = md_wd; e.live = 1'b1;
      mq.push_back(e);
    end
  endfunction

  task automatic step();
    model_eval();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; wb_valid = 1'b0; wb_a3 = 5'd0; wb_wd = 32'd0;
    md_valid = 1'b0; md_a3 = 5'd0; md_wd = 32'd0; q1 = 5'd0; q2 = 5'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    md_valid = 1'b1; md_a3 = 5'd6; md_wd = 32'hFFFF_0000;
    step();
    step();
    idle_inputs();
    #2;
    n_checks++;
    if ({md_ready, RegWrite, a3, WD, q1_pend, q2_pend} !== {1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state got ready=%b rw=%b a3=%0d wd=%h p=%b%b exp ready=1 rw=0 a3=0 wd=0 p=00",
               md_ready, RegWrite, a3, WD, q1_pend, q2_pend);
    end
    step();
  endtask

  task automatic test_single_push();
    logic        e_rw;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    idle_inputs();
    md_valid = 1'b1; md_a3 = 5'd5; md_wd = 32'h0000_1234;
    #2;
    e_rw = BYP; e_a3 = BYP ? 5'd5 : 5'd0; e_wd = BYP ? 32'h0000_1234 : 32'd0;
    n_checks++;
    if ({RegWrite, a3, WD, md_ready} !== {e_rw, e_a3, e_wd, 1'b1}) begin
      n_fail++;
      $display("FAIL single_push_c0 got rw=%b a3=%0d wd=%h ready=%b exp rw=%b a3=%0d wd=%h ready=1",
               RegWrite, a3, WD, md_ready, e_rw, e_a3, e_wd);
    end
    step();
    idle_inputs();
    #2;
    e_rw = !BYP; e_a3 = BYP ? 5'd0 : 5'd5; e_wd = BYP ? 32'd0 : 32'h0000_1234;
    n_checks++;
    if ({RegWrite, a3, WD} !== {e_rw, e_a3, e_wd}) begin
      n_fail++;
      $display("FAIL single_push_c1 got rw=%b a3=%0d wd=%h exp rw=%b a3=%0d wd=%h",
               RegWrite, a3, WD, e_rw, e_a3, e_wd);
    end
    step();
    #2;
    n_checks++;
    if ({RegWrite, md_ready} !== {1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL single_push_c2 got rw=%b ready=%b exp rw=0 ready=1", RegWrite, md_ready);
    end
    step();
  endtask

  task automatic test_wb_hold();
    logic [4:0]  src_a3 [3];
    logic [31:0] src_wd [3];
    logic [31:0] obs[$];
    int idx;
    src_a3[0] = 5'd10; src_a3[1] = 5'd11; src_a3[2] = 5'd12;
    src_wd[0] = 32'hAAAA_0001; src_wd[1] = 32'hAAAA_0002; src_wd[2] = 32'hAAAA_0003;
    idx = 0;
    idle_inputs();
    for (int c = 0; c < 10; c++) begin
      wb_valid = (c < 4); wb_a3 = 5'd3; wb_wd = 32'hBEEF_0000 + 32'(c);
      md_valid = (idx < 3);
      md_a3 = (idx < 3) ? src_a3[idx] : 5'd0;
      md_wd = (idx < 3) ? src_wd[idx] : 32'd0;
      #2;
      model_eval();
      n_checks++;
      if ({md_ready, RegWrite, a3, WD} !== {exp_ready, exp_rw, exp_a3, exp_wd}) begin
        n_fail++;
        $display("FAIL wb_hold_port c=%0d got ready=%b rw=%b a3=%0d wd=%h exp ready=%b rw=%b a3=%0d wd=%h",
                 c, md_ready, RegWrite, a3, WD, exp_ready, exp_rw, exp_a3, exp_wd);
      end
      if (c < 4) begin
        n_checks++;
        if ({RegWrite, a3} !== {1'b1, 5'd3}) begin
          n_fail++;
          $display("FAIL wb_hold_wb c=%0d got rw=%b a3=%0d exp rw=1 a3=3", c, RegWrite, a3);
        end
      end
      if (c == 2 || c == 3) begin
        n_checks++;
        if (md_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL wb_hold_full c=%0d got ready=%b exp ready=0", c, md_ready);
        end
      end
      if (RegWrite === 1'b1 && a3 !== 5'd3) obs.push_back(WD);
      if (md_valid && exp_ready) idx++;
      step();
    end
    n_checks++;
    if (obs.size() != 3) begin
      n_fail++;
      $display("FAIL wb_hold_count got %0d writes exp 3", obs.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs[k] !== src_wd[k]) begin
          n_fail++;
          $display("FAIL wb_hold_order k=%0d got wd=%h exp wd=%h", k, obs[k], src_wd[k]);
        end
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_kill();
    idle_inputs();
    q1 = 5'd7;
    wb_valid = 1'b1; wb_a3 = 5'd2; wb_wd = 32'h0000_0022;
    md_valid = 1'b1; md_a3 = 5'd7; md_wd = 32'h0000_0077;
    #2;
    n_checks++;
    if ({RegWrite, a3, q1_pend} !== {1'b1, 5'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL kill_c0 got rw=%b a3=%0d p1=%b exp rw=1 a3=2 p1=0", RegWrite, a3, q1_pend);
    end
    step();
    md_valid = 1'b0; md_a3 = 5'd0; md_wd = 32'd0;
    #2;
    n_checks++;
    if ({RegWrite, a3, q1_pend} !== {1'b1, 5'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL kill_pend_before got rw=%b a3=%0d p1=%b exp rw=1 a3=2 p1=1", RegWrite, a3, q1_pend);
    end
    step();
    wb_a3 = 5'd7; wb_wd = 32'h0000_0700;
    #2;
    n_checks++;
    if ({RegWrite, a3, WD, q1_pend} !== {1'b1, 5'd7, 32'h0000_0700, 1'b1}) begin
      n_fail++;
      $display("FAIL kill_wb_write got rw=%b a3=%0d wd=%h p1=%b exp rw=1 a3=7 wd=00000700 p1=1",
               RegWrite, a3, WD, q1_pend);
    end
    step();
    wb_valid = 1'b0; wb_a3 = 5'd0; wb_wd = 32'd0;
    #2;
    n_checks++;
    if ({RegWrite, a3, q1_pend} !== {1'b0, 5'd7, 1'b0}) begin
      n_fail++;
      $display("FAIL kill_dead_pop got rw=%b a3=%0d p1=%b exp rw=0 a3=7 p1=0", RegWrite, a3, q1_pend);
    end
    step();
    #2;
    n_checks++;
    if ({RegWrite, a3, md_ready} !== {1'b0, 5'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL kill_empty got rw=%b a3=%0d ready=%b exp rw=0 a3=0 ready=1", RegWrite, a3, md_ready);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_zero_dest();
    idle_inputs();
    md_valid = 1'b1; md_a3 = 5'd0; md_wd = 32'hDEAD_BEEF;
    wb_valid = 1'b1; wb_a3 = 5'd0; wb_wd = 32'h5555_5555;
    #2;
    n_checks++;
    if ({RegWrite, a3, WD, md_ready, q1_pend, q2_pend} !== {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL zero_dest_c0 got rw=%b a3=%0d wd=%h ready=%b p=%b%b exp rw=0 a3=0 wd=0 ready=1 p=00",
               RegWrite, a3, WD, md_ready, q1_pend, q2_pend);
    end
    step();
    idle_inputs();
    #2;
    n_checks++;
    if ({RegWrite, a3, WD} !== {1'b0, 5'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL zero_dest_c1 got rw=%b a3=%0d wd=%h exp rw=0 a3=0 wd=0", RegWrite, a3, WD);
    end
    step();
  endtask

  task automatic test_reset_full();
    idle_inputs();
    wb_valid = 1'b1; wb_a3 = 5'd4; wb_wd = 32'h0000_0004;
    md_valid = 1'b1; md_a3 = 5'd20; md_wd = 32'h0000_00A0;
    step();
    md_a3 = 5'd21; md_wd = 32'h0000_00A1;
    step();
    #2;
    n_checks++;
    if (md_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_full_pre got ready=%b exp ready=0", md_ready);
    end
    wb_valid = 1'b0; wb_a3 = 5'd0;
    reset = 1'b1;
    md_a3 = 5'd22; md_wd = 32'h0000_00A2;
    step();
    idle_inputs();
    #2;
    n_checks++;
    if ({md_ready, RegWrite, a3, WD} !== {1'b1, 1'b0, 5'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_full_post got ready=%b rw=%b a3=%0d wd=%h exp ready=1 rw=0 a3=0 wd=0",
               md_ready, RegWrite, a3, WD);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      #2;
      n_checks++;
      if (RegWrite !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_full_stale c=%0d got rw=%b a3=%0d exp rw=0", c, RegWrite, a3);
      end
    end
    step();
  endtask

  task automatic test_full_stream();
    logic [31:0] obs[$];
    int idx;
    idx = 0;
    idle_inputs();
    for (int c = 0; c < 14; c++) begin
      wb_valid = (c < 2); wb_a3 = 5'd9; wb_wd = 32'h0000_0009;
      md_valid = (idx < 6);
      md_a3 = (idx < 6) ? 5'(13 + idx) : 5'd0;
      md_wd = (idx < 6) ? (32'hC000_0000 + 32'(idx)) : 32'd0;
      #2;
      model_eval();
      n_checks++;
      if ({md_ready, RegWrite, a3, WD} !== {exp_ready, exp_rw, exp_a3, exp_wd}) begin
        n_fail++;
        $display("FAIL stream_port c=%0d got ready=%b rw=%b a3=%0d wd=%h exp ready=%b rw=%b a3=%0d wd=%h",
                 c, md_ready, RegWrite, a3, WD, exp_ready, exp_rw, exp_a3, exp_wd);
      end
      if (c == 2) begin
        n_checks++;
        if (md_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL stream_full got ready=%b exp ready=0", md_ready);
        end
      end
      if (!wb_valid && RegWrite === 1'b1) obs.push_back(WD);
      if (md_valid && exp_ready) idx++;
      step();
    end
    n_checks++;
    if (obs.size() != 6) begin
      n_fail++;
      $display("FAIL stream_count got %0d writes exp 6", obs.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_checks++;
        if (obs[k] !== (32'hC000_0000 + 32'(k))) begin
          n_fail++;
          $display("FAIL stream_order k=%0d got wd=%h exp wd=%h", k, obs[k], 32'hC000_0000 + 32'(k));
        end
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset    = ($urandom_range(0, 59) == 0);
      wb_valid = ($urandom_range(0, 2) == 0);
      wb_a3    = 5'($urandom_range(0, 7));
      wb_wd    = $urandom;
      md_valid = ($urandom_range(0, 1) == 1);
      md_a3    = 5'($urandom_range(0, 7));
      md_wd    = $urandom;
      q1       = 5'($urandom_range(0, 7));
      q2       = 5'($urandom_range(0, 7));
      #2;
      model_eval();
      n_checks++;
      if (reset) begin
        if (md_ready !== exp_ready) begin
          n_fail++;
          $display("FAIL rnd_reset_ready c=%0d got ready=%b exp ready=%b", c, md_ready, exp_ready);
        end
      end else if ({md_ready, RegWrite, a3, WD, q1_pend, q2_pend} !==
                   {exp_ready, exp_rw, exp_a3, exp_wd, exp_p1, exp_p2}) begin
        n_fail++;
        $display("FAIL rnd c=%0d got ready=%b rw=%b a3=%0d wd=%h p=%b%b exp ready=%b rw=%b a3=%0d wd=%h p=%b%b",
                 c, md_ready, RegWrite, a3, WD, q1_pend, q2_pend,
                 exp_ready, exp_rw, exp_a3, exp_wd, exp_p1, exp_p2);
      end
      step();
    end
    idle_inputs();
    step();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_push();
    test_wb_hold();
    test_kill();
    test_zero_dest();
    test_reset_full();
    test_full_stream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
